ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX register outputs, applies the forwarding muxes, and computes the ALU result. It holds an iterative multiply/divide unit with HI/LO registers, and registers its results into the EX/MEM pipeline register. While a multiply or divide is running it asserts stall_E, and the upstream stages (PC, IF/ID, ID/EX) hold.

Parameters:
WIDTH, 32, datapath width; fixed at 32 for MIPS-I, parameterised only for the bench.
MD_ITER, 32, multiply/divide iterations (one bit per cycle); must equal WIDTH.

Ports:
clk  in  1  rising-edge clock
clr  in  1  synchronous active-high reset
RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E, ALUSrc_E, RegDst_E  in  1 each  control bits from ID/EX
ALUfunc_E  in  6  MIPS funct code
shamt_E  in  5  shift amount
regA_E, regB_E  in  32  register-file read data (rs, rt)
Rb_E, Rd_E  in  5  rt and rd indices
SignIm_E  in  32  sign-extended immediate
ForwardA_E, ForwardB_E  in  2  forwarding select: 00 = regX_E, 01 = ResultW, 10 = ALUOut_M, 11 = regX_E
ResultW  in  32  writeback-stage result
stall_E  out  1  combinational; hold request to upstream stages
RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M  out  1 each  registered control
ALUOut_M  out  32  registered ALU result
WriteData_M  out  32  registered forwarded rt value (store data)
WriteReg_M  out  5  registered destination: RegDst_E ? Rd_E : Rb_E

Behaviour:
- Reset (clr=1 at a rising edge) sets:
  - all _M outputs to 0;
  - HI and LO to 0;
  - the MD FSM to IDLE and the iteration counter to 0.
  - clr has priority over every other event, including mid-operation: a BUSY operation is abandoned and HI/LO are zeroed.
- Operands:
  - A = forwarded rs.
  - Bf = forwarded rt.
  - B = ALUSrc_E ? SignIm_E : Bf.
- ALU result (combinational) by ALUfunc_E:
  - 20h/21h: A+B. 22h/23h: A−B. Overflow is ignored (no trap).
  - 24h AND, 25h OR, 26h XOR, 27h NOR.
  - 2Ah: signed A<B → 1 else 0. 2Bh: unsigned compare, same encoding.
  - 00h: Bf<<shamt_E. 02h: logical right. 03h: arithmetic right.
  - 10h: HI. 12h: LO.
  - 18h MULT, 19h MULTU, 1Ah DIV, 1Bh DIVU: result 0.
  - Any other code: result 0.
- EX/MEM register:
  - Captures every non-stalled cycle.
  - When stall_E=1 it captures a bubble: all four control bits 0; data and WriteReg hold their previous values.
- MD FSM, states IDLE, BUSY, DONE:
  - IDLE: if ALUfunc_E is in 18h–1Bh, then stall_E=1 combinationally. Latch operand magnitudes (signed ops take absolute values), record result signs, counter←0, go to BUSY.
  - BUSY: stall_E=1. Each cycle performs one shift-add (multiply) or one restoring-subtract (divide) step, counter+1. After step MD_ITER (counter reaches 31 and steps), go to DONE.
  - DONE: stall_E=0. Write the sign-corrected result into HI/LO at this edge, go to IDLE. The MD instruction then leaves EX as a normal instruction; decode supplies RegWrite=0.
  - Latency: stall_E is high for 1+MD_ITER = 33 consecutive cycles. HI/LO are valid to an MFHI/MFLO in EX on the cycle after DONE.
- Result rules:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO = FFFFFFFFh, HI = dividend; same 33-cycle latency.
  - DIV 80000000h / FFFFFFFFh: LO = 80000000h, HI = 0.
- The operands latched at launch are used for the whole operation. Forwarding changes during BUSY have no effect.

Test Plan:
- ADD with ForwardA=10, previous ALUOut_M=5, regB_E=7, ALUSrc=0, RegDst=1, Rd=3 → next edge: ALUOut_M=12, WriteReg_M=3, RegWrite_M follows input; stall_E=0.
- SLT/SLTU with A=FFFFFFFFh, B=1 → SLT gives ALUOut_M=1, SLTU gives ALUOut_M=0. SRA with Bf=80000000h, shamt=4 → ALUOut_M=F8000000h.
- MULT −3 × 5 → stall_E high for exactly 33 cycles and M-stage control bits 0 throughout; then MFLO gives FFFFFFF1h and MFHI gives FFFFFFFFh.
- DIV −7 / 2 → LO=FFFFFFFDh, HI=FFFFFFFFh. DIVU 9 / 0 → LO=FFFFFFFFh, HI=9.
- clr asserted on the 10th BUSY cycle of a MULTU → next cycle: stall_E=0, FSM IDLE, all _M outputs 0, MFHI/MFLO return 0.
- Back-to-back: DIVU immediately followed by MFLO → MFLO in EX the cycle after DONE returns the new quotient.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (forwarding, ALU, iterative mul/div with HI/LO, EX/MEM register, stall_E to upstream)
module ex_stage #(
  parameter int WIDTH   = 32,
  parameter int MD_ITER = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             RegWrite_E,
  input  logic             MemToReg_E,
  input  logic             MemWrite_E,
  input  logic             MemRead_E,
  input  logic             ALUSrc_E,
  input  logic             RegDst_E,
  input  logic [5:0]       ALUfunc_E,
  input  logic [4:0]       shamt_E,
  input  logic [WIDTH-1:0] regA_E,
  input  logic [WIDTH-1:0] regB_E,
  input  logic [4:0]       Rb_E,
  input  logic [4:0]       Rd_E,
  input  logic [WIDTH-1:0] SignIm_E,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  input  logic [WIDTH-1:0] ResultW,
  output logic             stall_E,
  output logic             RegWrite_M,
  output logic             MemToReg_M,
  output logic             MemWrite_M,
  output logic             MemRead_M,
  output logic [WIDTH-1:0] ALUOut_M,
  output logic [WIDTH-1:0] WriteData_M,
  output logic [4:0]       WriteReg_M
);
  localparam int CW = $clog2(MD_ITER);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  md_state_t state, state_n;
  logic [WIDTH-1:0] a, bf, b, alu, hi, lo, mc, ma, mb, diff, q_fix, r_fix;
  logic [2*WIDTH-1:0] p, p_n, prod;
  logic [WIDTH:0] sum, t;
  logic [CW-1:0] cnt;
  logic is_md, div_op, is_div, sa, sb, neg_q, neg_r, dz, ge;
  always_comb begin
    a = ForwardA_E == 2'b01 ? ResultW : ForwardA_E == 2'b10 ? ALUOut_M : regA_E;
    bf = ForwardB_E == 2'b01 ? ResultW : ForwardB_E == 2'b10 ? ALUOut_M : regB_E;
    b = ALUSrc_E ? SignIm_E : bf;
    is_md = ALUfunc_E[5:2] == 4'b0110;
    div_op = ALUfunc_E[1];
    sa = ~ALUfunc_E[0] & a[WIDTH-1];
    sb = ~ALUfunc_E[0] & bf[WIDTH-1];
    ma = sa ? -a : a;
    mb = sb ? -bf : bf;
    stall_E = state == BUSY || (state == IDLE && is_md);
    state_n = state == IDLE ? (is_md ? BUSY : IDLE) :
              state == BUSY ? (cnt == CW'(MD_ITER - 1) ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    alu = '0;
    case (ALUfunc_E)
      6'h20, 6'h21: alu = a + b;
      6'h22, 6'h23: alu = a - b;
      6'h24: alu = a & b;
      6'h25: alu = a | b;
      6'h26: alu = a ^ b;
      6'h27: alu = ~(a | b);
      6'h2A: alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      6'h2B: alu = {{(WIDTH-1){1'b0}}, a < b};
      6'h00: alu = bf << shamt_E;
      6'h02: alu = bf >> shamt_E;
      6'h03: alu = $signed(bf) >>> shamt_E;
      6'h10: alu = hi;
      6'h12: alu = lo;
      default: alu = '0;
    endcase
  end
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : '0);
    t = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    ge = t >= {1'b0, mc};
    diff = t[WIDTH-1:0] - mc;
    p_n = is_div ? {ge ? diff : t[WIDTH-1:0], p[WIDTH-2:0], ge} : {sum, p[WIDTH-1:1]};
    prod = neg_q ? -p : p;
    q_fix = dz ? '1 : neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    r_fix = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      p <= '0;
      mc <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      {RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M} <= 4'b0;
      ALUOut_M <= '0;
      WriteData_M <= '0;
      WriteReg_M <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && is_md) begin
        cnt <= '0;
        p <= {{WIDTH{1'b0}}, div_op ? ma : mb};
        mc <= div_op ? mb : ma;
        is_div <= div_op;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        dz <= bf == '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        p <= p_n;
      end else if (state == DONE) begin
        hi <= is_div ? r_fix : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? q_fix : prod[WIDTH-1:0];
      end
      {RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M} <= stall_E ? 4'b0 : {RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E};
      if (!stall_E) begin
        ALUOut_M <= alu;
        WriteData_M <= bf;
        WriteReg_M <= RegDst_E ? Rd_E : Rb_E;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;
  logic clk = 1'b0, clr;
  logic RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E, ALUSrc_E, RegDst_E;
  logic [5:0] ALUfunc_E;
  logic [4:0] shamt_E, Rb_E, Rd_E, WriteReg_M;
  logic [31:0] regA_E, regB_E, SignIm_E, ResultW, ALUOut_M, WriteData_M;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic stall_E, RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M;
  always #5 clk = ~clk;
  ex_stage dut (
    .clk(clk), .clr(clr),
    .RegWrite_E(RegWrite_E), .MemToReg_E(MemToReg_E), .MemWrite_E(MemWrite_E),
    .MemRead_E(MemRead_E), .ALUSrc_E(ALUSrc_E), .RegDst_E(RegDst_E),
    .ALUfunc_E(ALUfunc_E), .shamt_E(shamt_E), .regA_E(regA_E), .regB_E(regB_E),
    .Rb_E(Rb_E), .Rd_E(Rd_E), .SignIm_E(SignIm_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .stall_E(stall_E), .RegWrite_M(RegWrite_M), .MemToReg_M(MemToReg_M),
    .MemWrite_M(MemWrite_M), .MemRead_M(MemRead_M), .ALUOut_M(ALUOut_M),
    .WriteData_M(WriteData_M), .WriteReg_M(WriteReg_M)
  );
  int pass_cnt = 0, total_cnt = 0, phase = 0, stall_seen = 0;
  logic chk_en = 1'b0;
  logic [31:0] m_alu, m_wd, m_hi, m_lo, r_hi, r_lo, e_alu, e_bf;
  logic [4:0] m_wr, e_wr;
  logic [3:0] m_ctrl, e_ctrl;
  logic exp_stall;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r);
    return s == 2'b01 ? ResultW : s == 2'b10 ? m_alu : r;
  endfunction
  function automatic logic [31:0] alu_f(input logic [5:0] f, input logic [31:0] a, b, bf, input logic [4:0] sh);
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return bf << sh;
      6'h02: return bf >> sh;
      6'h03: return 32'(longint'(int'(bf)) >>> sh);
      6'h10: return m_hi;
      6'h12: return m_lo;
      default: return 32'd0;
    endcase
  endfunction
  task automatic md_calc(input logic [5:0] f, input logic [31:0] a, b);
    longint p;
    case (f)
      6'h18: begin p = longint'(int'(a)) * longint'(int'(b)); {r_hi, r_lo} = p; end
      6'h19: {r_hi, r_lo} = {32'b0, a} * {32'b0, b};
      6'h1A: begin
        if (b == 0) begin r_lo = '1; r_hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r_lo = 32'h80000000; r_hi = 0; end
        else begin r_lo = int'(a) / int'(b); r_hi = int'(a) % int'(b); end
      end
      default: begin
        if (b == 0) begin r_lo = '1; r_hi = a; end
        else begin r_lo = a / b; r_hi = a % b; end
      end
    endcase
  endtask
  task automatic eval();
    logic [31:0] a, bf, b;
    a = fwd(ForwardA_E, regA_E);
    bf = fwd(ForwardB_E, regB_E);
    b = ALUSrc_E ? SignIm_E : bf;
    if (phase == 0 && ALUfunc_E inside {[6'h18:6'h1B]}) begin
      md_calc(ALUfunc_E, a, bf);
      phase = 1;
    end
    exp_stall = phase >= 1 && phase <= 33;
    e_alu = alu_f(ALUfunc_E, a, b, bf, shamt_E);
    e_bf = bf;
    e_wr = RegDst_E ? Rd_E : Rb_E;
    e_ctrl = {RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E};
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (clr) begin
      m_alu = 0; m_wd = 0; m_wr = 0; m_ctrl = 0; m_hi = 0; m_lo = 0; phase = 0;
    end else begin
      m_ctrl = exp_stall ? 4'b0 : e_ctrl;
      if (!exp_stall) begin m_alu = e_alu; m_wd = e_bf; m_wr = e_wr; end
      if (phase == 34) begin m_hi = r_hi; m_lo = r_lo; phase = 0; end
      else if (phase > 0) phase++;
    end
  endtask
  task automatic run();
    stall_seen = 0;
    do begin
      if (phase > 0) ResultW = $urandom;
      eval();
      @(negedge clk);
      if (stall_E) stall_seen++;
      step();
    end while (phase != 0);
  endtask
  task automatic op(input logic [5:0] f, input logic [31:0] ra, rb, input logic [1:0] fa, fb,
                    input logic src, input logic [31:0] imm, input logic [4:0] sh);
    ALUfunc_E = f; regA_E = ra; regB_E = rb; ForwardA_E = fa; ForwardB_E = fb;
    ALUSrc_E = src; SignIm_E = imm; shamt_E = sh;
    {RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E, RegDst_E} = 5'($urandom);
    Rb_E = 5'($urandom);
    Rd_E = 5'($urandom);
    run();
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_E", 32'(stall_E), 32'(exp_stall));
      chk("ctrl_M", 32'({RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M}), 32'(m_ctrl));
      chk("ALUOut_M", ALUOut_M, m_alu);
      chk("WriteData_M", WriteData_M, m_wd);
      chk("WriteReg_M", 32'(WriteReg_M), 32'(m_wr));
    end
  end
  initial begin
    logic [5:0] fl [21] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                            6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F, 6'h01};
    logic [31:0] ra, rb;
    clr = 1'b1;
    {RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E, ALUSrc_E, RegDst_E} = '0;
    ALUfunc_E = 6'h20; shamt_E = 0; regA_E = 0; regB_E = 0; Rb_E = 0; Rd_E = 0;
    SignIm_E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
    step();
    step();
    chk("rst_ALUOut_M", ALUOut_M, 0);
    chk("rst_ctrl_M", 32'({RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M}), 0);
    chk("rst_WriteReg_M", 32'(WriteReg_M), 0);
    chk("rst_stall_E", 32'(stall_E), 0);
    clr = 1'b0;
    chk_en = 1'b1;
    op(6'h20, 0, 0, 2'b00, 2'b00, 1'b1, 5, 0);
    chk("addi_5", ALUOut_M, 5);
    ALUfunc_E = 6'h20; regA_E = 32'hDEAD; regB_E = 7; ForwardA_E = 2'b10; ForwardB_E = 2'b00;
    ALUSrc_E = 0; RegDst_E = 1; Rd_E = 3; Rb_E = 9; RegWrite_E = 1;
    {MemToReg_E, MemWrite_E, MemRead_E} = 3'b000;
    run();
    chk("add_fwd_alu", ALUOut_M, 12);
    chk("add_fwd_wreg", 32'(WriteReg_M), 3);
    chk("add_fwd_regwrite", 32'(RegWrite_M), 1);
    chk("add_no_stall", stall_seen, 0);
    op(6'h2A, 32'hFFFFFFFF, 1, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("slt", ALUOut_M, 1);
    op(6'h2B, 32'hFFFFFFFF, 1, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("sltu", ALUOut_M, 0);
    op(6'h03, 0, 32'h80000000, 2'b00, 2'b00, 1'b0, 0, 4);
    chk("sra", ALUOut_M, 32'hF8000000);
    op(6'h18, -3, 5, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("mult_stall_cycles", stall_seen, 33);
    op(6'h12, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("mult_lo", ALUOut_M, 32'hFFFFFFF1);
    op(6'h10, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("mult_hi", ALUOut_M, 32'hFFFFFFFF);
    op(6'h1A, -7, 2, 2'b00, 2'b00, 1'b0, 0, 0);
    op(6'h12, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("div_lo", ALUOut_M, 32'hFFFFFFFD);
    op(6'h10, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("div_hi", ALUOut_M, 32'hFFFFFFFF);
    op(6'h1B, 9, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("divu0_stall_cycles", stall_seen, 33);
    op(6'h12, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("divu0_lo", ALUOut_M, 32'hFFFFFFFF);
    op(6'h10, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("divu0_hi", ALUOut_M, 9);
    op(6'h1A, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b0, 0, 0);
    op(6'h12, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("divovf_lo", ALUOut_M, 32'h80000000);
    op(6'h10, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("divovf_hi", ALUOut_M, 0);
    ALUfunc_E = 6'h19; regA_E = 32'hFFFFFFFF; regB_E = 32'h12345; ForwardA_E = 0; ForwardB_E = 0;
    RegWrite_E = 1;
    do begin
      eval();
      step();
    end while (phase != 11);
    clr = 1'b1;
    eval();
    step();
    clr = 1'b0;
    chk("clr_ALUOut_M", ALUOut_M, 0);
    chk("clr_WriteData_M", WriteData_M, 0);
    chk("clr_ctrl_M", 32'({RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M}), 0);
    op(6'h10, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("clr_no_stall", stall_seen, 0);
    chk("clr_hi", ALUOut_M, 0);
    op(6'h12, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("clr_lo", ALUOut_M, 0);
    op(6'h1B, 100, 7, 2'b00, 2'b00, 1'b0, 0, 0);
    op(6'h12, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0);
    chk("b2b_divu_lo", ALUOut_M, 14);
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom);
      if ($urandom_range(0, 15) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      ResultW = $urandom;
      op(fl[$urandom_range(0, 20)], ra, rb, 2'($urandom), 2'($urandom), 1'($urandom), $urandom, 5'($urandom));
    end
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
